relu_stage_ctrl: RTL and testbench

//  Sequencer for the ReLU activation array. Each activation tile is R*C words.
//  - Accepts tiles from the convolution stage over a valid/ready handshake.
//  - Drives the array's clr/en_act/en_act_out strobes.
//  - Presents results downstream with backpressure.
//  - Counts tiles per feature map; pulses done after the last tile.

---
 rtl/relu_stage_ctrl.sv | 127 ++++++++++++
 tb/tb_relu_stage_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stage_ctrl.sv
// ReLU activation array sequencer: tile handshakes, array strobes,
// downstream backpressure and per-map tile counting.
module relu_stage_ctrl #(
    parameter int CNT_W   = 16,
    parameter int CLR_CYC = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_tiles,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             act_clr,
    output logic             en_act,
    output logic             en_act_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tile_cnt
);

    localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_EVAL,
        S_HOLD,
        S_FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cfg_q;
    logic [CCW-1:0]   clr_cnt;
    logic             load_q;
    logic [CNT_W-1:0] tile_nxt;

    assign tile_nxt = tile_cnt + CNT_W'(1);

    // Ready is a registered LOAD flag, so it never depends on in_valid.
    assign in_ready = load_q;
    assign en_act   = load_q & in_valid;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= S_IDLE;
            cfg_q      <= '0;
            tile_cnt   <= '0;
            clr_cnt    <= '0;
            load_q     <= 1'b0;
            act_clr    <= 1'b0;
            en_act_out <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            act_clr    <= 1'b0;
            en_act_out <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_q    <= cfg_tiles;
                        tile_cnt <= '0;
                        busy     <= 1'b1;
                        act_clr  <= 1'b1;
                        if (cfg_tiles != '0) begin
                            state   <= S_CLEAR;
                            clr_cnt <= '0;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == CCW'(CLR_CYC - 1)) begin
                        state  <= S_LOAD;
                        load_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + CCW'(1);
                        act_clr <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        state      <= S_EVAL;
                        load_q     <= 1'b0;
                        en_act_out <= 1'b1;
                    end
                end
                S_EVAL: begin
                    state     <= S_HOLD;
                    out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        tile_cnt  <= tile_nxt;
                        // Last tile also clears the array so stale Z never looks valid.
                        if (tile_nxt == cfg_q) begin
                            state   <= S_FIN;
                            done    <= 1'b1;
                            act_clr <= 1'b1;
                        end else begin
                            state  <= S_LOAD;
                            load_q <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    load_q    <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_stage_ctrl.sv
// Directed bench for relu_stage_ctrl with a small array model and
// a scoreboard of expected rectified tiles.
module tb_relu_stage_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             clr;
    logic             start;
    logic [CNT_W-1:0] cfg_tiles;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             act_clr;
    logic             en_act;
    logic             en_act_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] tile_cnt;

    relu_stage_ctrl #(.CNT_W(CNT_W), .CLR_CYC(1)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .cfg_tiles  (cfg_tiles),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .act_clr    (act_clr),
        .en_act     (en_act),
        .en_act_out (en_act_out),
        .busy       (busy),
        .done       (done),
        .tile_cnt   (tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: four signed bytes per tile on X, rectified onto Z.
    logic [31:0] x, xr, z;

    function automatic logic [31:0] relu4(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = v[i*8 + 7] ? 8'h00 : v[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (act_clr) begin
            xr <= '0;
            z  <= '0;
        end else begin
            if (en_act)     xr <= relu4(x);
            if (en_act_out) z  <= xr;
        end
    end

    logic [31:0] xrow [3];
    logic [31:0] zrow [3];

    int vec;
    int miss;
    int cyc_n;
    logic [31:0] sb [$];
    int          hs [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_map(input int cfg, input int stall, input bit poke);
        int          exp_cnt;
        int          done_seen;
        int          last_out;
        int          stall_left;
        int          tin;
        logic        prev_ov;
        logic [31:0] zhold;
        exp_cnt    = 0;
        done_seen  = 0;
        last_out   = -100;
        stall_left = 0;
        tin        = 0;
        prev_ov    = 1'b0;
        zhold      = '0;
        sb.delete();
        hs.delete();
        cfg_tiles = CNT_W'(cfg);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        for (int k = 0; k < 300; k++) begin
            start = 1'b0;
            if (poke && k == 3) begin
                start     = 1'b1;
                cfg_tiles = CNT_W'(7);
            end
            x = xrow[tin % 3];
            if (out_valid && !prev_ov) stall_left = stall;
            out_ready = (stall_left == 0);
            #1;
            if (k == 0) chk("clear_strobe", 32'(act_clr), 32'd1);
            if (in_ready && in_valid) begin
                chk("en_act", 32'(en_act), 32'd1);
                sb.push_back(zrow[tin % 3]);
                hs.push_back(cyc_n);
                tin++;
            end
            if (out_valid && !prev_ov) begin
                zhold = z;
                chk("hs_pending", 32'(hs.size() > 0), 32'd1);
                if (hs.size() > 0)
                    chk("latency", 32'(cyc_n - hs.pop_front()), 32'd2);
            end
            if (stall_left > 0) begin
                chk("bp_valid", 32'(out_valid), 32'd1);
                chk("bp_ready", 32'(in_ready), 32'd0);
                chk("bp_cnt", 32'(tile_cnt), 32'(exp_cnt));
                chk("bp_z", z, zhold);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                chk("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("z_data", z, sb.pop_front());
                chk("tile_cnt", 32'(tile_cnt), 32'(exp_cnt));
                exp_cnt++;
                last_out = cyc_n;
            end
            if (done) begin
                chk("done_gap", 32'(cyc_n - last_out), 32'd1);
                chk("final_cnt", 32'(tile_cnt), 32'(cfg));
                chk("fin_clr", 32'(act_clr), 32'd1);
                done_seen++;
            end
            prev_ov = out_valid;
            if (done) break;
            tick();
        end
        chk("done_once", 32'(done_seen), 32'd1);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        tick();
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("done_low", 32'(done), 32'd0);
        chk("cnt_hold", 32'(tile_cnt), 32'(cfg));
    endtask

    initial begin
        vec   = 0;
        miss  = 0;
        cyc_n = 0;
        xrow[0] = 32'hFF0700FB;
        zrow[0] = 32'h00070000;
        xrow[1] = 32'h7F80FE03;
        zrow[1] = 32'h7F000003;
        xrow[2] = 32'h0101FFFF;
        zrow[2] = 32'h01010000;
        clr       = 1'b0;
        start     = 1'b0;
        cfg_tiles = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;

        tick();
        tick();
        #1;
        chk("rst_outs",
            32'({in_ready, out_valid, act_clr, en_act, en_act_out,
                 busy, done, tile_cnt}), 32'd0);
        clr = 1'b1;
        tick();
        #1;
        chk("idle_busy0", 32'(busy), 32'd0);

        run_map(3, 0, 1'b0);
        run_map(2, 5, 1'b1);

        cfg_tiles = '0;
        in_valid  = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_en_act", 32'(en_act), 32'd0);
        chk("zero_ready", 32'(in_ready), 32'd0);
        tick();
        #1;
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_idle", 32'(busy), 32'd0);
        chk("zero_en_act2", 32'(en_act), 32'd0);

        cfg_tiles = CNT_W'(3);
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) break;
            tick();
        end
        chk("reach_hold", 32'(out_valid), 32'd1);
        clr = 1'b0;
        #1;
        chk("async_rst",
            32'({in_ready, out_valid, act_clr, en_act, en_act_out,
                 busy, done, tile_cnt}), 32'd0);
        tick();
        clr       = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        run_map(1, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
